// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative HI/LO multiply/divide sequencer.
//
// Runs mult/multu/div/divu one bit per clock on operand magnitudes. The
// result sign is fixed up in a final cycle, and then the unit writes the
// architectural HI/LO registers. mthi/mtlo writes and a pipeline flush are
// also handled here.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst_n    - synchronous active-low reset
//   start    - issue request, sampled only while idle
//   op       - 00 mult, 01 multu, 10 div, 11 divu
//   rs_val   - multiplicand / dividend (sampled at the start edge)
//   rt_val   - multiplier / divisor    (sampled at the start edge)
//   flush    - cancels an in-flight operation, HI/LO left untouched
//   hi_we    - mthi strobe (honoured only when not busy)
//   lo_we    - mtlo strobe (honoured only when not busy)
//   wdata    - mthi/mtlo data
//   busy     - operation in flight
//   done     - one-cycle pulse, HI/LO updated this cycle
//   hi, lo   - architectural HI/LO registers
//   div_zero - (MULDIV_DIVZERO_FLAG_EN only) pulses with done when a
//              div/divu completed with a zero divisor
//
// Optional feature macro: MULDIV_DIVZERO_FLAG_EN adds the div_zero output.

module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIVZERO_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic               is_div;     // latched op[1]
  logic               neg_res;    // negate product / quotient in FIX
  logic               neg_rem;    // negate remainder in FIX
  logic [WIDTH-1:0]   opnd;       // |multiplicand| or |divisor|
  logic [2*WIDTH-1:0] acc;        // mult: {partial, multiplier}; div: {rem, quo}
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic               dz_q;
`endif

  // Operand conditioning for the start edge. Only op[0]=0 is signed.
  logic             rs_neg, rt_neg, rt_zero, accept;
  logic [WIDTH-1:0] rs_abs, rt_abs;

  assign rs_neg  = ~op[0] & rs_val[WIDTH-1];
  assign rt_neg  = ~op[0] & rt_val[WIDTH-1];
  assign rs_abs  = rs_neg ? -rs_val : rs_val;
  assign rt_abs  = rt_neg ? -rt_val : rt_val;
  assign rt_zero = (rt_val == '0);
  assign accept  = (state == IDLE) && start && !flush;

  // One iteration of shift-add or restoring shift-subtract.
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // NOTE: every signal driven here gets a value on every path first, so no
  // latch can be inferred.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    acc_step = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      // Borrow clear: divisor fits, keep the difference and shift in a 1.
      if (!div_diff[WIDTH]) acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                  acc_step = {acc[2*WIDTH-2:0], 1'b0};
    end
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // NOTE: the arithmetic datapath has no reset; it is always loaded at the
  // start edge before it is read, so only control state and HI/LO are reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div  <= op[1];
      // A zero divisor yields all-ones quotient and the raw dividend as
      // remainder, so the quotient must not be sign-flipped in that case.
      neg_res <= (rs_neg ^ rt_neg) & ~(op[1] & rt_zero);
      neg_rem <= rs_neg;
      if (op[1]) begin
        acc  <= {{WIDTH{1'b0}}, rs_abs};
        opnd <= rt_abs;
      end else begin
        acc  <= {{WIDTH{1'b0}}, rt_abs};
        opnd <= rs_abs;
      end
`ifdef MULDIV_DIVZERO_FLAG_EN
      dz_q <= op[1] & rt_zero;
`endif
    end else if (state == CALC) begin
      acc <= acc_step;
    end
  end

  // Control FSM and architectural registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
`ifdef MULDIV_DIVZERO_FLAG_EN
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
      div_zero <= 1'b0;
`endif
      if (flush && busy) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
            if (start && !flush) begin
              state <= CALC;
              busy  <= 1'b1;
              count <= '0;
            end
          end
          CALC: begin
            count <= count + 1'b1;
            if (count == LAST) state <= FIX;
          end
          FIX: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
`ifdef MULDIV_DIVZERO_FLAG_EN
            div_zero <= dz_q;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq (WIDTH=32).
// Directed cases from the test plan, control interactions (ignored start,
// ignored mthi, flush, mid-operation reset) and randomized operations
// compared against an arithmetic reference model.

module tb_muldiv_seq;

  localparam int W   = 32;
  localparam int LAT = W + 1;   // start edge to done edge

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_val, rt_val;
  logic         flush, hi_we, lo_we;
  logic [W-1:0] wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
  logic         div_zero;
`endif

  muldiv_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
`ifdef MULDIV_DIVZERO_FLAG_EN
    ,
    .div_zero (div_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model: {hi, lo} from plain arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint    sa, sb;
    int signed ia, ib;
    logic [31:0] q, r;
    case (o)
      2'b00: begin
        sa = $signed(a);
        sb = $signed(b);
        return 64'(sa * sb);
      end
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        ia = $signed(a);
        ib = $signed(b);
        q  = 32'(ia / ib);
        r  = 32'(ia % ib);
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation (optionally with an mtlo in the same cycle) and
  // follow it to its done pulse.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic with_we, input logic [31:0] wd);
    logic [63:0] exp;
    int cyc, busy_cnt;
    exp    = model(o, a, b);
    op     = o;
    rs_val = a;
    rt_val = b;
    start  = 1'b1;
    lo_we  = with_we;
    wdata  = wd;
    step();
    start  = 1'b0;
    lo_we  = 1'b0;
    check({tag, " busy@start"}, 64'(busy), 64'd1);
    check({tag, " done low@start"}, 64'(done), 64'd0);
    if (with_we) check({tag, " lo write with start"}, 64'(lo), 64'(wd));
`ifdef MULDIV_DIVZERO_FLAG_EN
    check({tag, " div_zero low@start"}, 64'(div_zero), 64'd0);
`endif
    // Operands may change freely after the start edge.
    rs_val   = $urandom;
    rt_val   = $urandom;
    cyc      = 0;
    busy_cnt = 1;
    while (!done && cyc < 100) begin
      step();
      cyc++;
      if (busy) busy_cnt++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(LAT));
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'(LAT));
    check({tag, " hi/lo"}, {hi, lo}, exp);
`ifdef MULDIV_DIVZERO_FLAG_EN
    check({tag, " div_zero"}, 64'(div_zero), 64'(o[1] && b == 0));
`endif
  endtask

  // Mult with interference: start at cycle 5 and mthi at cycle 6 (both
  // ignored), then kill=0 completes, kill=1 flushes, kill=2 resets at 10.
  task automatic ctl_seq(input string tag, input int kill);
    logic [63:0] exp;
    logic done_seen;
    int cyc;
    exp    = model(2'b00, 32'd7, 32'hFFFF_FFFD);
    op     = 2'b00;
    rs_val = 32'd7;
    rt_val = 32'hFFFF_FFFD;
    start  = 1'b1;
    step();
    done_seen = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      start  = (e == 5);
      op     = 2'b11;
      rs_val = $urandom;
      rt_val = $urandom;
      hi_we  = (e == 6);
      wdata  = 32'hDEAD_BEEF;
      flush  = (kill == 1 && e == 10);
      rst_n  = !(kill == 2 && e == 10);
      step();
      done_seen |= done;
    end
    start = 1'b0;
    hi_we = 1'b0;
    flush = 1'b0;
    rst_n = 1'b1;
    check({tag, " busy@10"}, 64'(busy), (kill == 0) ? 64'd1 : 64'd0);
    if (kill == 0) begin
      check({tag, " hi_we ignored"}, 64'(hi), 64'h3C3C_3C3C);
      cyc = 10;
      while (!done && cyc < 100) begin
        step();
        cyc++;
      end
      check({tag, " latency"}, 64'(cyc), 64'(LAT));
      check({tag, " hi/lo"}, {hi, lo}, exp);
    end else begin
      for (int i = 0; i < 30; i++) begin
        step();
        done_seen |= done | busy;
      end
      check({tag, " no done/busy after kill"}, 64'(done_seen), 64'd0);
      if (kill == 1) check({tag, " hi/lo kept"}, {hi, lo}, {32'h3C3C_3C3C, 32'hA5A5_A5A5});
      else           check({tag, " hi/lo reset"}, {hi, lo}, 64'd0);
    end
  endtask

  task automatic mt_init();
    lo_we = 1'b1;
    wdata = 32'hA5A5_A5A5;
    step();
    lo_we = 1'b0;
    hi_we = 1'b1;
    wdata = 32'h3C3C_3C3C;
    step();
    hi_we = 1'b0;
    check("mtlo/mthi", {hi, lo}, {32'h3C3C_3C3C, 32'hA5A5_A5A5});
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    rs_val = '0;
    rt_val = '0;
    flush  = 1'b0;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    wdata  = '0;
    step();
    step();
    check("reset hi/lo", {hi, lo}, 64'd0);
    check("reset busy/done", {62'd0, busy, done}, 64'd0);
`ifdef MULDIV_DIVZERO_FLAG_EN
    check("reset div_zero", 64'(div_zero), 64'd0);
`endif
    rst_n = 1'b1;
    step();

    // Test-plan directed cases, issued back to back.
    run_op("mult 2*-1",      2'b00, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, '0);
    run_op("multu 2*ffff",   2'b01, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, '0);
    run_op("div dddd/2",     2'b10, 32'hDDDD_DDDD, 32'h0000_0002, 1'b0, '0);
    run_op("divu dddd/2",    2'b11, 32'hDDDD_DDDD, 32'h0000_0002, 1'b0, '0);
    run_op("divu by zero",   2'b11, 32'h1234_5678, 32'h0000_0000, 1'b0, '0);
    run_op("div neg by zero",2'b10, 32'h8765_4321, 32'h0000_0000, 1'b0, '0);
    run_op("div overflow",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '0);
    run_op("mult minint sq", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, '0);
    run_op("mtlo with start",2'b00, 32'h0000_0002, 32'h0000_0003, 1'b1, 32'h1234_5678);

    // flush together with start while idle: start ignored.
    step();
    start = 1'b1;
    flush = 1'b1;
    step();
    start = 1'b0;
    flush = 1'b0;
    check("flush+start idle", 64'(busy), 64'd0);

    mt_init();
    ctl_seq("ctl ignore", 0);
    step();
    mt_init();
    ctl_seq("ctl flush", 1);
    run_op("after flush", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, '0);
    mt_init();
    ctl_seq("ctl reset", 2);

    // Randomized operations against the model.
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      run_op($sformatf("rand%0d op%0d", n, ro), ro, ra, rb, 1'b0, '0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
